// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - UART register-port sequencer: divider init, status polling, RX buffer, round-robin TX
module uart_ctrl #(
    parameter logic [15:0] CLK_DIV   = 16'd103,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        bus_sel_out,
    output logic        bus_read_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_address_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        tx0_valid_in,
    input  logic [7:0]  tx0_data_in,
    output logic        tx0_ready_out,
    input  logic        tx1_valid_in,
    input  logic [7:0]  tx1_data_in,
    output logic        tx1_ready_out,
    output logic        rx_valid_out,
    output logic [7:0]  rx_data_out,
    input  logic        rx_ready_in,
    output logic        init_done_out
);

    localparam logic [1:0] S_INIT     = 2'd0;
    localparam logic [1:0] S_POLL     = 2'd1;
    localparam logic [1:0] S_RX_READ  = 2'd2;
    localparam logic [1:0] S_TX_WRITE = 2'd3;

    logic [1:0] r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic [7:0] r_tx_data;
    logic       r_rx_full;
    logic [7:0] r_rx_data;
    logic       r_init_done;

    logic w_rx_ok;
    logic w_tx_ok;
    logic w_pick;
    logic w_unused;

    assign w_rx_ok  = bus_read_value_in[1] && !r_rx_full;
    assign w_tx_ok  = bus_read_value_in[0] && (tx0_valid_in || tx1_valid_in);
    // On a tie the requester that did not win last time gets the slot.
    assign w_pick   = (tx0_valid_in && tx1_valid_in) ? ~r_last_grant : tx1_valid_in;
    assign w_unused = ^bus_read_value_in[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_INIT;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_tx_data    <= 8'd0;
            r_rx_full    <= 1'b0;
            r_rx_data    <= 8'd0;
            r_init_done  <= 1'b0;
        end else begin
            if (r_rx_full && rx_ready_in)
                r_rx_full <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_state     <= S_POLL;
                    r_init_done <= 1'b1;
                end
                S_POLL: begin
                    if (w_rx_ok) begin
                        r_state <= S_RX_READ;
                    end else if (w_tx_ok) begin
                        r_state   <= S_TX_WRITE;
                        r_grant   <= w_pick;
                        // Requesters hold data until ready, so capturing here equals the write-cycle value.
                        r_tx_data <= w_pick ? tx1_data_in : tx0_data_in;
                    end
                end
                S_RX_READ: begin
                    r_rx_data <= bus_read_value_in[7:0];
                    r_rx_full <= 1'b1;
                    r_state   <= S_POLL;
                end
                default: begin
                    r_last_grant <= r_grant;
                    r_state      <= S_POLL;
                end
            endcase
        end
    end

    // Bus outputs decode from the state; gating with reset_n keeps them 0 while reset is held.
    always_comb begin
        bus_sel_out         = 1'b0;
        bus_read_out        = 1'b0;
        bus_write_mask_out  = 4'b0000;
        bus_address_out     = 32'd0;
        bus_write_value_out = 32'd0;
        tx0_ready_out       = 1'b0;
        tx1_ready_out       = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_INIT: begin
                    bus_sel_out         = 1'b1;
                    bus_address_out     = BASE_ADDR;
                    bus_write_mask_out  = 4'b0011;
                    bus_write_value_out = {16'd0, CLK_DIV};
                end
                S_POLL: begin
                    bus_sel_out     = 1'b1;
                    bus_address_out = BASE_ADDR + 32'd4;
                end
                S_RX_READ: begin
                    bus_sel_out     = 1'b1;
                    bus_read_out    = 1'b1;
                    bus_address_out = BASE_ADDR + 32'd8;
                end
                default: begin
                    bus_sel_out         = 1'b1;
                    bus_write_mask_out  = 4'b0001;
                    bus_address_out     = BASE_ADDR + 32'd8;
                    bus_write_value_out = {24'd0, r_tx_data};
                    tx0_ready_out       = !r_grant;
                    tx1_ready_out       = r_grant;
                end
            endcase
        end
    end

    assign rx_valid_out  = r_rx_full;
    assign rx_data_out   = r_rx_data;
    assign init_done_out = r_init_done;

endmodule
